vr_rr_arbiter: RTL and testbench

- Shares the single downstream valid/ready sink (the backpressuring DUT) between NUM_REQ upstream valid/ready requesters.
- Uses round-robin arbitration with burst locking:
  - a grant is held until the requester signals last, or until MAX_BURST beats have transferred;
  - the grant then rotates.
- Sits between the driver-side channels and the DUT drv_intf.
- Includes a stall watchdog that flags downstream ready held low longer than the DUT contract permits.

---
 rtl/vr_rr_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_vr_rr_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vr_rr_arbiter.sv
// Round-robin valid/ready arbiter with burst locking and a downstream stall watchdog.
// Several upstream requesters share one downstream sink. A grant is held until the
// owner sends a last beat or MAX_BURST beats have moved. After that there is one idle
// cycle, and the search restarts just past the previous owner.
module vr_rr_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned STALL_LIMIT = 8,
  localparam int unsigned SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // Upstream requesters
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_last,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  // Downstream sink
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [DATA_W-1:0]         o_out_data,
  output logic                      o_out_last,
  output logic [SRC_W-1:0]          o_out_src,
  // Watchdog
  output logic                      o_stall_err,
  input  logic                      i_clr_err
);

  // One spare bit so ptr + offset can be reduced modulo NUM_REQ without overflow.
  localparam int unsigned CAND_W = SRC_W + 1;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

  state_e             r_state;
  state_e             w_state_next;

  logic [SRC_W-1:0]   r_ptr;
  logic [SRC_W-1:0]   r_src;
  logic [3:0]         r_beat_cnt;
  logic [7:0]         r_stall_cnt;
  logic [7:0]         w_stall_cnt_next;
  logic               r_stall_err;

  logic               w_pick_found;
  logic [SRC_W-1:0]   w_pick_idx;
  logic [CAND_W-1:0]  w_cand;

  logic [DATA_W-1:0]  w_data_arr [NUM_REQ];
  logic               w_g_valid;
  logic               w_g_last;
  logic [DATA_W-1:0]  w_g_data;
  logic               w_xfer;
  logic               w_burst_full;
  logic               w_stall;
  logic               w_trip;

  // Split the packed payload bus into one word per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_data_arr[gi] = i_req_data[gi*DATA_W +: DATA_W];
  end

  // Signals of the currently granted requester.
  assign w_g_valid = i_req_valid[r_src];
  assign w_g_last  = i_req_last[r_src];
  assign w_g_data  = w_data_arr[r_src];

  assign w_xfer       = o_out_valid && i_out_ready;
  // This transfer would be beat number MAX_BURST of the grant.
  assign w_burst_full = ({1'b0, r_beat_cnt} + 5'd1) == 5'(MAX_BURST);

  // Round-robin search: first valid requester from ptr+1 upward, wrapping at NUM_REQ.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    w_cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + CAND_W'(k);
      if (w_cand >= CAND_W'(NUM_REQ)) begin
        w_cand = w_cand - CAND_W'(NUM_REQ);
      end
      if (!w_pick_found && i_req_valid[w_cand[SRC_W-1:0]]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_cand[SRC_W-1:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: pick in idle; hold the grant until last or a full burst.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_pick_found) begin
          w_state_next = StGrant;
        end
      end
      StGrant: begin
        if (w_xfer && (w_g_last || w_burst_full)) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: in a grant, mux the owner through; the ready goes only to the owner.
  always_comb begin
    o_out_valid = 1'b0;
    o_out_data  = '0;
    o_out_last  = 1'b0;
    o_req_ready = '0;
    if (r_state == StGrant) begin
      o_out_valid        = w_g_valid;
      o_out_data         = w_g_data;
      o_out_last         = w_g_last;
      o_req_ready[r_src] = i_out_ready;
    end
  end

  // Grant bookkeeping: latch the winner and count the beats moved under the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= SRC_W'(NUM_REQ - 1);
      r_src      <= '0;
      r_beat_cnt <= '0;
    end else if (r_state == StIdle) begin
      if (w_pick_found) begin
        r_ptr      <= w_pick_idx;
        r_src      <= w_pick_idx;
        r_beat_cnt <= '0;
      end
    end else if (w_xfer) begin
      r_beat_cnt <= r_beat_cnt + 4'd1;
    end
  end

  assign o_out_src = r_src;

  // Watchdog: count consecutive stalled cycles, saturating at the limit.
  assign w_stall = o_out_valid && !i_out_ready;

  always_comb begin
    w_stall_cnt_next = '0;
    if (w_stall) begin
      if (r_stall_cnt >= 8'(STALL_LIMIT)) begin
        w_stall_cnt_next = r_stall_cnt;
      end else begin
        w_stall_cnt_next = r_stall_cnt + 8'd1;
      end
    end
  end

  // A trip is any stalled cycle that leaves the counter at the limit.
  assign w_trip = w_stall && (w_stall_cnt_next == 8'(STALL_LIMIT));

  // Watchdog state: a sticky error flag, where a new trip beats a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_cnt_next;
      if (w_trip) begin
        r_stall_err <= 1'b1;
      end else if (i_clr_err) begin
        r_stall_err <= 1'b0;
      end
    end
  end

  assign o_stall_err = r_stall_err;

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Bench for vr_rr_arbiter. Drivers push each issued beat into a per-source scoreboard.
// A negedge monitor pops and checks every downstream transfer. A transaction-level
// model predicts grant ownership, burst ends and the watchdog flag.
module tb_vr_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int SL = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    i_req_valid;
  logic [N-1:0]    i_req_last;
  logic [N*DW-1:0] i_req_data;
  logic [N-1:0]    o_req_ready;
  logic            o_out_valid;
  logic            i_out_ready;
  logic [DW-1:0]   o_out_data;
  logic            o_out_last;
  logic [1:0]      o_out_src;
  logic            o_stall_err;
  logic            i_clr_err;

  vr_rr_arbiter #(
    .NUM_REQ    (N),
    .DATA_W     (DW),
    .MAX_BURST  (MB),
    .STALL_LIMIT(SL)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req_valid(i_req_valid),
    .i_req_last (i_req_last),
    .i_req_data (i_req_data),
    .o_req_ready(o_req_ready),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_out_data (o_out_data),
    .o_out_last (o_out_last),
    .o_out_src  (o_out_src),
    .o_stall_err(o_stall_err),
    .i_clr_err  (i_clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t drv_q [N][$];
  beat_t exp_q [N][$];
  bit    pres [N];
  int    grant_log[$];
  int    beats_log[$];
  int    n_xfer;
  int    rdy_mode;
  bit    rdy_force;
  bit    gap_mode;
  int    low_run;

  // Reference model state
  int    m_owner;
  bit    m_idle;
  int    m_beats;
  int    m_stall;
  bit    m_err;
  bit    m_stall_now;
  bit    m_last;
  beat_t m_eb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Round-robin rule: the nearest valid requester after the previous owner.
  function automatic int next_owner(input int last, input logic [N-1:0] v);
    for (int d = 1; d <= N; d++) begin
      if (v[(last + d) % N]) return (last + d) % N;
    end
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) begin
      if (drv_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Monitor and reference model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_req_ready", o_req_ready, 0);
        chk("rst_out_src", o_out_src, 0);
        chk("rst_stall_err", o_stall_err, 0);
        m_owner = N - 1;
        m_idle  = 1'b1;
        m_beats = 0;
        m_stall = 0;
        m_err   = 1'b0;
      end else begin
        chk("stall_err", o_stall_err, m_err);
        m_stall_now = o_out_valid && !i_out_ready;
        if (m_idle) begin
          chk("idle_out_valid", o_out_valid, 0);
          chk("idle_req_ready", o_req_ready, 0);
          if (|i_req_valid) begin
            m_owner = next_owner(m_owner, i_req_valid);
            m_idle  = 1'b0;
            m_beats = 0;
            grant_log.push_back(m_owner);
          end
        end else begin
          chk("out_src", o_out_src, m_owner);
          chk("out_valid", o_out_valid, i_req_valid[m_owner]);
          chk("req_ready", o_req_ready, i_out_ready ? (32'd1 << m_owner) : 32'd0);
          if (i_req_valid[m_owner] && i_out_ready) begin
            n_xfer++;
            m_beats++;
            if (exp_q[m_owner].size() == 0) begin
              chk("beat_without_expect", exp_q[m_owner].size(), 1);
              m_last = i_req_last[m_owner];
            end else begin
              m_eb = exp_q[m_owner].pop_front();
              chk("out_data", o_out_data, m_eb.data);
              chk("out_last", o_out_last, m_eb.last);
              m_last = m_eb.last;
            end
            if (m_last || m_beats == MB) begin
              m_idle = 1'b1;
              beats_log.push_back(m_beats);
            end
          end
        end
        if (m_stall_now) m_stall = (m_stall < SL) ? m_stall + 1 : SL;
        else m_stall = 0;
        if (m_stall_now && m_stall == SL) m_err = 1'b1;
        else if (i_clr_err) m_err = 1'b0;
      end
    end
  end

  task automatic update_inputs();
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && drv_q[i].size() > 0 && (!gap_mode || $urandom_range(0, 3) != 0)) begin
        pres[i] = 1'b1;
      end
      i_req_valid[i] = pres[i];
      if (pres[i]) begin
        i_req_data[i*DW +: DW] = drv_q[i][0].data;
        i_req_last[i]          = drv_q[i][0].last;
      end else begin
        i_req_data[i*DW +: DW] = 8'($urandom);
        i_req_last[i]          = 1'($urandom);
      end
    end
    case (rdy_mode)
      0: i_out_ready = 1'b1;
      1: begin
        if (low_run >= 6) i_out_ready = 1'b1;
        else i_out_ready = ($urandom_range(0, 2) != 0);
        low_run = i_out_ready ? 0 : low_run + 1;
      end
      default: i_out_ready = rdy_force;
    endcase
  endtask

  // One clock: note handshakes before the edge, then retire them and drive new inputs.
  task automatic cycle();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = o_req_ready & i_req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && drv_q[i].size() > 0) begin
        void'(drv_q[i].pop_front());
        pres[i] = 1'b0;
      end
    end
    update_inputs();
  endtask

  task automatic enqueue(input int i, input int len, input bit with_last);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = 8'($urandom);
      b.last = with_last && (k == len - 1);
      drv_q[i].push_back(b);
      exp_q[i].push_back(b);
    end
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
      pres[i] = 1'b0;
    end
    i_req_valid = '0;
    i_req_last  = '0;
    i_req_data  = '0;
    i_out_ready = 1'b1;
    i_clr_err   = 1'b0;
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    grant_log.delete();
    beats_log.delete();
    n_xfer = 0;
  endtask

  task automatic do_reset();
    assert_reset();
    release_reset();
  endtask

  task automatic set_ready(input bit v);
    rdy_force   = v;
    i_out_ready = v;
  endtask

  task automatic wait_bursts(input int n, input int bound, input string name);
    for (int c = 0; c < bound && beats_log.size() < n; c++) cycle();
    chk(name, beats_log.size() >= n, 1);
  endtask

  int total;
  bit done;

  initial begin
    rdy_mode  = 0;
    rdy_force = 1'b1;
    gap_mode  = 1'b0;
    low_run   = 0;
    do_reset();

    // Lone requester 2: three beats with last, then a second packet after one bubble.
    enqueue(2, 3, 1'b1);
    enqueue(2, 2, 1'b1);
    cycle();
    cycle();
    chk("t1_first_valid", o_out_valid, 1);
    chk("t1_first_src", o_out_src, 2);
    wait_bursts(2, 40, "t1_timeout");
    if (beats_log.size() >= 2) begin
      chk("t1_grant0", grant_log[0], 2);
      chk("t1_grant1", grant_log[1], 2);
      chk("t1_beats0", beats_log[0], 3);
      chk("t1_beats1", beats_log[1], 2);
    end

    // All four requesters continuously valid without last: bursts cut at MAX_BURST.
    do_reset();
    for (int i = 0; i < N; i++) enqueue(i, 12, 1'b0);
    wait_bursts(5, 60, "t2_timeout");
    if (beats_log.size() >= 5) begin
      chk("t2_order0", grant_log[0], 0);
      chk("t2_order1", grant_log[1], 1);
      chk("t2_order2", grant_log[2], 2);
      chk("t2_order3", grant_log[3], 3);
      chk("t2_order4", grant_log[4], 0);
      for (int k = 0; k < 4; k++) chk("t2_beats", beats_log[k], MB);
    end

    // Requester 1 ends early with last while 0 and 3 wait; the pointer sits at 1.
    do_reset();
    enqueue(1, 2, 1'b1);
    cycle();
    cycle();
    enqueue(0, 2, 1'b1);
    enqueue(3, 2, 1'b1);
    wait_bursts(3, 40, "t3_timeout");
    if (beats_log.size() >= 3) begin
      chk("t3_beats1", beats_log[0], 2);
      chk("t3_order0", grant_log[0], 1);
      chk("t3_order1", grant_log[1], 3);
      chk("t3_order2", grant_log[2], 0);
    end

    // Backpressure: a 7-cycle stall is tolerated; an 8-cycle stall trips the watchdog.
    do_reset();
    rdy_mode = 2;
    set_ready(1'b1);
    enqueue(0, 4, 1'b1);
    cycle();
    cycle();
    cycle();
    set_ready(1'b0);
    repeat (7) cycle();
    chk("t4_data_held", o_out_data, exp_q[0][0].data);
    chk("t4_no_err_7", o_stall_err, 0);
    set_ready(1'b1);
    cycle();
    set_ready(1'b0);
    repeat (8) cycle();
    chk("t4_err_8", o_stall_err, 1);
    repeat (2) cycle();
    chk("t4_err_sticky", o_stall_err, 1);
    set_ready(1'b1);
    i_clr_err = 1'b1;
    cycle();
    i_clr_err = 1'b0;
    chk("t4_err_cleared", o_stall_err, 0);
    wait_bursts(1, 20, "t4_timeout");
    if (beats_log.size() >= 1) chk("t4_beats", beats_log[0], 4);
    rdy_mode = 0;

    // Reset during beat 2 of a burst from requester 3.
    do_reset();
    enqueue(3, 4, 1'b1);
    cycle();
    cycle();
    cycle();
    chk("t5_pre_valid", o_out_valid, 1);
    chk("t5_pre_src", o_out_src, 3);
    assert_reset();
    #1;
    chk("t5_rst_valid", o_out_valid, 0);
    chk("t5_rst_ready", o_req_ready, 0);
    release_reset();
    for (int i = 0; i < N; i++) enqueue(i, 2, 1'b1);
    wait_bursts(4, 40, "t5_timeout");
    if (grant_log.size() >= 1) chk("t5_first_grant", grant_log[0], 0);

    // Random traffic, gaps and bounded backpressure, 1000 beats in total.
    do_reset();
    gap_mode = 1'b1;
    rdy_mode = 1;
    total    = 0;
    while (total < 1000) begin
      int i;
      int len;
      i   = $urandom_range(0, N - 1);
      len = $urandom_range(1, 6);
      if (total + len > 1000) len = 1000 - total;
      enqueue(i, len, 1'b1);
      total += len;
    end
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      cycle();
      done = all_empty();
    end
    chk("t6_drain", done, 1);
    chk("t6_beat_count", n_xfer, total);
    chk("t6_stall_err", o_stall_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "global timeout");
  end

endmodule
